// File: rtl/j1_cpu_if.sv
// j1_cpu_if: code fetch port and data load/store port between the J1 core and its dual-port RAM
interface j1_cpu_if;
  logic [12:0] code_addr;
  logic [15:0] insn;
  logic [12:0] mem_addr;
  logic        mem_wr;
  logic [15:0] dout;
  logic [15:0] din;
  modport master (output code_addr, mem_addr, mem_wr, dout, input insn, din);
  modport slave (input code_addr, mem_addr, mem_wr, dout, output insn, din);
endinterface

// File: rtl/j1_cpu.sv
// j1_cpu: 16-bit J1 Forth stack CPU, one instruction per clock on a dual-port code/data RAM.
// Define J1_DEPTH_EN to make ALU op 14 report {rsp,dsp}; otherwise op 14 returns zero.
module j1_cpu (
  input  logic     clk,
  input  logic     reset,
  j1_cpu_if.master bus
);
  logic [12:0] pc, pc_n, pc1;
  logic [15:0] t, t_n, n, r, alu, rwd, depth;
  logic [3:0]  dsp, dsp_n, rsp, rsp_n;
  logic        reboot, dwe, rwe;
  logic [15:0] dstack [16];
  logic [15:0] rstack [16];
  assign n = dstack[dsp];
  assign r = rstack[rsp];
  assign pc1 = pc + 13'd1;
`ifdef J1_DEPTH_EN
  assign depth = {4'b0, rsp, 4'b0, dsp};
`else
  assign depth = 16'h0000;
`endif
  always_comb begin
    alu = t;
    case (bus.insn[11:8])
      4'd0:  alu = t;
      4'd1:  alu = n;
      4'd2:  alu = t + n;
      4'd3:  alu = t & n;
      4'd4:  alu = t | n;
      4'd5:  alu = t ^ n;
      4'd6:  alu = ~t;
      4'd7:  alu = {16{n == t}};
      4'd8:  alu = {16{$signed(n) < $signed(t)}};
      4'd9:  alu = n >> t[3:0];
      4'd10: alu = t - 16'd1;
      4'd11: alu = r;
      4'd12: alu = bus.din;
      4'd13: alu = n << t[3:0];
      4'd14: alu = depth;
      4'd15: alu = {16{n < t}};
    endcase
  end
  // The reboot cycle discards whatever the RAM presented before pc 0 was fetched.
  always_comb begin
    pc_n = pc1;
    t_n = t;
    dsp_n = dsp;
    rsp_n = rsp;
    dwe = 1'b0;
    rwe = 1'b0;
    rwd = t;
    if (reboot) pc_n = 13'd0;
    else if (bus.insn[15]) begin
      dsp_n = dsp + 4'd1;
      dwe = 1'b1;
      t_n = {1'b0, bus.insn[14:0]};
    end else case (bus.insn[14:13])
      2'b00: pc_n = bus.insn[12:0];
      2'b01: begin
        pc_n = (t == 16'd0) ? bus.insn[12:0] : pc1;
        dsp_n = dsp - 4'd1;
        t_n = n;
      end
      2'b10: begin
        pc_n = bus.insn[12:0];
        rsp_n = rsp + 4'd1;
        rwe = 1'b1;
        rwd = {2'b0, pc1, 1'b0};
      end
      default: begin
        pc_n = bus.insn[12] ? r[13:1] : pc1;
        t_n = alu;
        dsp_n = dsp + {{2{bus.insn[1]}}, bus.insn[1:0]};
        rsp_n = rsp + {{2{bus.insn[3]}}, bus.insn[3:2]};
        dwe = bus.insn[7] || bus.insn[1:0] == 2'b01;
        rwe = bus.insn[6];
      end
    endcase
  end
  assign bus.code_addr = pc_n;
  assign bus.mem_wr = !reboot && bus.insn[15:13] == 3'b011 && bus.insn[5];
  // Presenting next T lets the RAM have [T] ready when a fetch op runs next cycle.
  assign bus.mem_addr = bus.mem_wr ? t[13:1] : t_n[13:1];
  assign bus.dout = n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= 13'd0;
      t <= 16'd0;
      dsp <= 4'd0;
      rsp <= 4'd0;
      reboot <= 1'b1;
    end else begin
      pc <= pc_n;
      t <= t_n;
      dsp <= dsp_n;
      rsp <= rsp_n;
      reboot <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (dwe) dstack[dsp_n] <= t;
    if (rwe) rstack[rsp_n] <= rwd;
  end
endmodule

// File: tb/tb_j1_cpu.sv
// tb_j1_cpu: directed scenarios plus random programs run in lockstep with an instruction-level model
module tb_j1_cpu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_req = 1'b0;
  logic [15:0] image [8192];
  logic [15:0] mem [8192];
  int n_cmp = 0;
  int n_bad = 0;
  j1_cpu_if bus();
  j1_cpu dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (load_req) for (int a = 0; a < 8192; a++) mem[a] <= image[a];
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.dout;
    bus.insn <= mem[bus.code_addr];
    bus.din <= mem[bus.mem_addr];
  end
  int m_pc, m_dsp, m_rsp;
  logic [15:0] m_t, m_insn, m_din;
  logic [15:0] m_ds [16];
  logic [15:0] m_rs [16];
  logic [15:0] mm [8192];
  bit m_reboot;
  int nx_pc, nx_dsp, nx_rsp, e_maddr;
  logic [15:0] nx_t, e_dout, rsv;
  bit e_wr, dsw, rsw;
  task automatic fill;
    for (int a = 0; a < 8192; a++) image[a] = 16'h6000;
  endtask
  task automatic boot;
    reset = 1'b1;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic adv(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic model_init;
    for (int a = 0; a < 8192; a++) mm[a] = image[a];
    for (int a = 0; a < 16; a++) begin
      m_ds[a] = 16'h0;
      m_rs[a] = 16'h0;
    end
    m_pc = 0; m_dsp = 0; m_rsp = 0; m_t = 16'h0;
    m_reboot = 1'b1; m_insn = image[0]; m_din = image[0];
  endtask
  task automatic model_calc;
    logic [15:0] i, nn, rr, res;
    int dtab [4];
    int sh;
    dtab = '{0, 1, -2, -1};
    i = m_insn; nn = m_ds[m_dsp]; rr = m_rs[m_rsp];
    sh = int'(m_t[3:0]);
    nx_pc = m_pc; nx_t = m_t; nx_dsp = m_dsp; nx_rsp = m_rsp;
    dsw = 0; rsw = 0; rsv = 16'h0; e_wr = 0; res = m_t;
    if (!m_reboot) begin
      nx_pc = (m_pc + 1) % 8192;
      if (i[15]) begin
        nx_dsp = (m_dsp + 1) % 16; dsw = 1; nx_t = i & 16'h7FFF;
      end else if (i[14:13] == 2'd0) nx_pc = int'(i[12:0]);
      else if (i[14:13] == 2'd1) begin
        if (m_t == 16'h0) nx_pc = int'(i[12:0]);
        nx_dsp = (m_dsp + 15) % 16; nx_t = nn;
      end else if (i[14:13] == 2'd2) begin
        nx_pc = int'(i[12:0]); nx_rsp = (m_rsp + 1) % 16; rsw = 1;
        rsv = 16'(((m_pc + 1) % 8192) * 2);
      end else begin
        case (int'(i[11:8]))
          1: res = nn;
          2: res = 16'((int'(m_t) + int'(nn)) % 65536);
          3: res = m_t & nn;
          4: res = m_t | nn;
          5: res = m_t ^ nn;
          6: res = 16'hFFFF ^ m_t;
          7: res = (nn == m_t) ? 16'hFFFF : 16'h0;
          8: res = ((nn ^ 16'h8000) < (m_t ^ 16'h8000)) ? 16'hFFFF : 16'h0;
          9: res = 16'(int'(nn) / (1 << sh));
          10: res = 16'((int'(m_t) + 65535) % 65536);
          11: res = rr;
          12: res = m_din;
          13: res = 16'((longint'(nn) * (longint'(1) << sh)) % 65536);
`ifdef J1_DEPTH_EN
          14: res = 16'(m_rsp * 256 + m_dsp);
`else
          14: res = 16'h0;
`endif
          15: res = (nn < m_t) ? 16'hFFFF : 16'h0;
          default: res = m_t;
        endcase
        nx_t = res;
        nx_pc = i[12] ? (int'(rr) / 2) % 8192 : (m_pc + 1) % 8192;
        nx_dsp = (m_dsp + dtab[i[1:0]] + 16) % 16;
        nx_rsp = (m_rsp + dtab[i[3:2]] + 16) % 16;
        dsw = i[7] || i[1:0] == 2'b01;
        rsw = i[6]; rsv = m_t;
        e_wr = i[5];
      end
    end
    e_dout = nn;
    e_maddr = e_wr ? (int'(m_t) / 2) % 8192 : (int'(nx_t) / 2) % 8192;
  endtask
  task automatic model_commit;
    m_insn = mm[nx_pc];
    m_din = mm[e_maddr];
    if (e_wr) mm[e_maddr] = e_dout;
    if (dsw) m_ds[nx_dsp] = m_t;
    if (rsw) m_rs[nx_rsp] = rsv;
    m_pc = nx_pc; m_t = nx_t; m_dsp = nx_dsp; m_rsp = nx_rsp; m_reboot = 1'b0;
  endtask
  task automatic test_reset;
    fill();
    image[0] = 16'h0123;
    image[13'h123] = 16'h6020;
    boot();
    n_cmp++;
    if (bus.code_addr !== 13'h0) begin n_bad++; $display("FAIL reboot_code_addr got %h want 0000", bus.code_addr); end
    n_cmp++;
    if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL reboot_mem_wr got %b want 0", bus.mem_wr); end
    adv(1);
    n_cmp++;
    if (dut.pc !== 13'h0) begin n_bad++; $display("FAIL first_pc got %h want 0000", dut.pc); end
    n_cmp++;
    if (bus.code_addr !== 13'h123) begin n_bad++; $display("FAIL first_insn_jump got %h want 0123", bus.code_addr); end
    adv(1);
    n_cmp++;
    if (bus.mem_wr !== 1'b1) begin n_bad++; $display("FAIL store_strobe got %b want 1", bus.mem_wr); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL async_mem_wr got %b want 0", bus.mem_wr); end
    n_cmp++;
    if (bus.code_addr !== 13'h0) begin n_bad++; $display("FAIL async_code_addr got %h want 0000", bus.code_addr); end
    adv(1);
  endtask
  task automatic test_alu_plus;
    fill();
    image[0] = 16'h8005; image[1] = 16'h8003; image[2] = 16'h6203;
    boot();
    adv(4);
    n_cmp++;
    if (dut.t !== 16'h0008) begin n_bad++; $display("FAIL plus_t got %h want 0008", dut.t); end
    n_cmp++;
    if (dut.dsp !== 4'd1) begin n_bad++; $display("FAIL plus_dsp got %0d want 1", dut.dsp); end
  endtask
  task automatic test_branch;
    fill();
    image[0] = 16'h8007; image[1] = 16'h8000; image[2] = 16'h2020;
    image[16'h20] = 16'h8001; image[16'h21] = 16'h2030;
    boot();
    adv(4);
    n_cmp++;
    if (dut.pc !== 13'h20) begin n_bad++; $display("FAIL zbranch_taken_pc got %h want 0020", dut.pc); end
    n_cmp++;
    if (dut.t !== 16'h0007) begin n_bad++; $display("FAIL zbranch_t got %h want 0007", dut.t); end
    adv(2);
    n_cmp++;
    if (dut.pc !== 13'h22) begin n_bad++; $display("FAIL zbranch_fall_pc got %h want 0022", dut.pc); end
    n_cmp++;
    if (dut.dsp !== 4'd1) begin n_bad++; $display("FAIL zbranch_dsp got %0d want 1", dut.dsp); end
  endtask
  task automatic test_call;
    fill();
    image[0] = 16'h0010; image[16'h10] = 16'h4040; image[16'h40] = 16'h700C;
    boot();
    adv(3);
    n_cmp++;
    if (dut.pc !== 13'h40) begin n_bad++; $display("FAIL call_pc got %h want 0040", dut.pc); end
    n_cmp++;
    if (dut.rstack[dut.rsp] !== 16'h0022) begin n_bad++; $display("FAIL call_r got %h want 0022", dut.rstack[dut.rsp]); end
    n_cmp++;
    if (bus.code_addr !== 13'h11) begin n_bad++; $display("FAIL exit_code_addr got %h want 0011", bus.code_addr); end
    adv(1);
    n_cmp++;
    if (dut.rsp !== 4'd0) begin n_bad++; $display("FAIL exit_rsp got %0d want 0", dut.rsp); end
  endtask
  task automatic test_store_fetch;
    fill();
    image[0] = 16'h9234; image[1] = 16'h8100; image[2] = 16'h6023;
    image[3] = 16'h6000; image[4] = 16'h6C00;
    boot();
    adv(3);
    n_cmp++;
    if (bus.mem_wr !== 1'b1) begin n_bad++; $display("FAIL store_wr got %b want 1", bus.mem_wr); end
    n_cmp++;
    if (bus.mem_addr !== 13'h080) begin n_bad++; $display("FAIL store_addr got %h want 0080", bus.mem_addr); end
    n_cmp++;
    if (bus.dout !== 16'h1234) begin n_bad++; $display("FAIL store_dout got %h want 1234", bus.dout); end
    adv(3);
    n_cmp++;
    if (dut.t !== 16'h1234) begin n_bad++; $display("FAIL fetch_t got %h want 1234", dut.t); end
  endtask
  task automatic test_compare_wrap;
    fill();
    image[0] = 16'h8000; image[1] = 16'h6600; image[2] = 16'h8001; image[3] = 16'h6803;
    image[4] = 16'h8000; image[5] = 16'h6600; image[6] = 16'h8001; image[7] = 16'h6F03;
    boot();
    adv(5);
    n_cmp++;
    if (dut.t !== 16'hFFFF) begin n_bad++; $display("FAIL signed_lt got %h want ffff", dut.t); end
    adv(4);
    n_cmp++;
    if (dut.t !== 16'h0000) begin n_bad++; $display("FAIL unsigned_lt got %h want 0000", dut.t); end
    fill();
    for (int k = 0; k < 17; k++) image[k] = 16'h8000 | 16'(k + 1);
    boot();
    adv(19);
    n_cmp++;
    if (dut.dsp !== 4'd1) begin n_bad++; $display("FAIL dsp_wrap got %0d want 1", dut.dsp); end
    n_cmp++;
    if (dut.t !== 16'd17) begin n_bad++; $display("FAIL wrap_t got %h want 0011", dut.t); end
  endtask
  task automatic test_random;
    bit bad;
    for (int run = 0; run < 3; run++) begin
      for (int a = 0; a < 8192; a++) image[a] = 16'($urandom_range(0, 65535));
      for (int a = 0; a < 16; a++) image[a] = 16'h8000 | 16'($urandom_range(0, 32767));
      for (int a = 16; a < 32; a++) image[a] = 16'h6044;
      boot();
      model_init();
      bad = 0;
      for (int c = 0; c < 2500 && !bad; c++) begin
        model_calc();
        n_cmp++;
        if (dut.pc !== 13'(m_pc)) begin n_bad++; bad = 1; $display("FAIL rnd_pc cyc %0d got %h want %h", c, dut.pc, 13'(m_pc)); end
        n_cmp++;
        if (dut.t !== m_t) begin n_bad++; bad = 1; $display("FAIL rnd_t cyc %0d got %h want %h", c, dut.t, m_t); end
        n_cmp++;
        if (dut.dsp !== 4'(m_dsp)) begin n_bad++; bad = 1; $display("FAIL rnd_dsp cyc %0d got %0d want %0d", c, dut.dsp, m_dsp); end
        n_cmp++;
        if (dut.rsp !== 4'(m_rsp)) begin n_bad++; bad = 1; $display("FAIL rnd_rsp cyc %0d got %0d want %0d", c, dut.rsp, m_rsp); end
        n_cmp++;
        if (bus.code_addr !== 13'(nx_pc)) begin n_bad++; bad = 1; $display("FAIL rnd_code_addr cyc %0d got %h want %h", c, bus.code_addr, 13'(nx_pc)); end
        n_cmp++;
        if (bus.mem_wr !== e_wr) begin n_bad++; bad = 1; $display("FAIL rnd_mem_wr cyc %0d got %b want %b", c, bus.mem_wr, e_wr); end
        n_cmp++;
        if (bus.mem_addr !== 13'(e_maddr)) begin n_bad++; bad = 1; $display("FAIL rnd_mem_addr cyc %0d got %h want %h", c, bus.mem_addr, 13'(e_maddr)); end
        if (e_wr) begin
          n_cmp++;
          if (bus.dout !== e_dout) begin n_bad++; bad = 1; $display("FAIL rnd_dout cyc %0d got %h want %h", c, bus.dout, e_dout); end
        end
        model_commit();
        adv(1);
      end
    end
  endtask
  initial begin
    test_reset();
    test_alu_plus();
    test_branch();
    test_call();
    test_store_fetch();
    test_compare_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
